// File: rtl/watch_display.sv
// Four-digit multiplexed 7-segment driver for a mins:secs counter; one-clock registered outputs.
// Digits are captured once per scan frame so a frame is never torn by mid-scan input changes.
module watch_display #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] mins,
  input  logic [5:0] secs,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [3:0] DASH = 4'hA;

  typedef enum logic [1:0] {D0, D1, D2, D3} idx_t;

  idx_t          idx;
  logic [CW-1:0] cnt;
  logic [5:0]    snap_m;
  logic [5:0]    snap_s;
  logic          tc;
  logic [3:0]    dsel;

  assign tc = (cnt == CNT_MAX);

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    if (v >= 6'd50) return 4'd5;
    if (v >= 6'd40) return 4'd4;
    if (v >= 6'd30) return 4'd3;
    if (v >= 6'd20) return 4'd2;
    if (v >= 6'd10) return 4'd1;
    return 4'd0;
  endfunction

  // Values 60..63 show a dash on both digits of that field only.
  function automatic logic [3:0] digit(input logic [5:0] v, input logic hi);
    logic [3:0] t;
    logic [5:0] u;
    t = tens_of(v);
    u = v - ({2'b00, t} * 6'd10);
    if (v > 6'd59) return DASH;
    return hi ? t : u[3:0];
  endfunction

  always_comb begin
    dsel = 4'd0;
    case (idx)
      D0: dsel = digit(snap_s, 1'b0);
      D1: dsel = digit(snap_s, 1'b1);
      D2: dsel = digit(snap_m, 1'b0);
      D3: dsel = digit(snap_m, 1'b1);
      default: dsel = 4'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= D0;
      snap_m <= 6'd0;
      snap_s <= 6'd0;
      an     <= 4'b0000;
      seg    <= 7'h00;
      dp     <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + 1'b1;
      if (tc) begin
        case (idx)
          D0: idx <= D1;
          D1: idx <= D2;
          D2: idx <= D3;
          D3: idx <= D0;
          default: idx <= D0;
        endcase
        // Frame boundary: capture the next frame's digits.
        if (idx == D3) begin
          snap_m <= mins;
          snap_s <= secs;
        end
      end
      an  <= en ? (4'b0001 << idx) : 4'b0000;
      seg <= en ? enc(dsel) : 7'h00;
      dp  <= en && (idx == D2) && !snap_s[0];
    end
  end

endmodule

// File: tb/tb_watch_display.sv
// Bench for watch_display: frame-level vector table, hand-written corner sequences and random stimulus
// checked against an edge-count model of the scan and the per-frame capture.
module tb_watch_display;
  localparam int R = 4;
  localparam int FRAME = 4 * R;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [5:0] mins;
  logic [5:0] secs;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  always #5 clk = ~clk;

  watch_display #(.REFRESH_DIV(R)) dut (
    .clk(clk), .rst(rst), .en(en), .mins(mins), .secs(secs),
    .seg(seg), .an(an), .dp(dp)
  );

  int checks = 0;
  int errors = 0;

  // Model state: edges since reset release and the frame's captured values.
  int         n;
  logic [5:0] sm;
  logic [5:0] ss;

  typedef struct {
    logic [5:0] m;
    logic [5:0] s;
    logic [6:0] sg[4];
    logic       colon;
  } vec_t;

  vec_t tbl[4];

  function automatic logic [6:0] enc(int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  function automatic logic [6:0] field_seg(logic [5:0] v, bit tens);
    int iv;
    iv = int'(v);
    if (iv > 59) return 7'h40;
    return enc(tens ? iv / 10 : iv % 10);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int d;
    logic [3:0] ean;
    logic [6:0] eseg;
    logic       edp;
    @(posedge clk);
    d = (n / R) % 4;
    ean  = en ? (4'b0001 << d) : 4'b0000;
    case (d)
      0: eseg = field_seg(ss, 1'b0);
      1: eseg = field_seg(ss, 1'b1);
      2: eseg = field_seg(sm, 1'b0);
      default: eseg = field_seg(sm, 1'b1);
    endcase
    if (!en) eseg = 7'h00;
    edp = en && (d == 2) && !ss[0];
    n++;
    if (n % FRAME == 0) begin
      sm = mins;
      ss = secs;
    end
    #1;
    check("model_an", 32'(an), 32'(ean));
    check("model_seg", 32'(seg), 32'(eseg));
    check("model_dp", 32'(dp), 32'(edp));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    sm = 6'd0;
    ss = 6'd0;
  endtask

  initial begin
    tbl[0] = '{m: 6'd23, s: 6'd45, sg: '{7'h6D, 7'h66, 7'h4F, 7'h5B}, colon: 1'b0};
    tbl[1] = '{m: 6'd59, s: 6'd59, sg: '{7'h6F, 7'h6D, 7'h6F, 7'h6D}, colon: 1'b0};
    tbl[2] = '{m: 6'd0,  s: 6'd0,  sg: '{7'h3F, 7'h3F, 7'h3F, 7'h3F}, colon: 1'b1};
    tbl[3] = '{m: 6'd61, s: 6'd7,  sg: '{7'h07, 7'h3F, 7'h40, 7'h40}, colon: 1'b0};

    rst = 1'b1; en = 1'b1; mins = 6'd0; secs = 6'd0;
    #12;
    check("reset_an", 32'(an), 32'h0);
    check("reset_seg", 32'(seg), 32'h0);
    check("reset_dp", 32'(dp), 32'h0);
    release_reset();
    step();
    check("first_an", 32'(an), 32'h1);
    check("first_seg", 32'(seg), 32'h3F);
    repeat (FRAME - 1) step();

    // Table: capture during one frame, check every clock of the next.
    for (int i = 0; i < 4; i++) begin
      mins = tbl[i].m;
      secs = tbl[i].s;
      repeat (FRAME) step();
      for (int j = 0; j < FRAME; j++) begin
        step();
        check("tbl_an", 32'(an), 32'(4'b0001 << (j / R)));
        check("tbl_seg", 32'(seg), 32'(tbl[i].sg[j / R]));
        check("tbl_dp", 32'(dp), 32'((j / R == 2) && tbl[i].colon));
      end
    end

    // Input change mid-frame must not tear the frame on display.
    mins = 6'd23; secs = 6'd45;
    repeat (FRAME) step();
    repeat (R + 1) step();
    secs = 6'd46;
    repeat (R - 1) step();
    step();
    check("coh_old_seg", 32'(seg), 32'h4F);
    check("coh_old_dp", 32'(dp), 32'h0);
    repeat (2 * R - 1) step();
    step();
    check("coh_new_units", 32'(seg), 32'h7D);
    repeat (2 * R) step();
    check("coh_new_dp", 32'(dp), 32'h1);
    check("coh_new_an", 32'(an), 32'h4);

    // Enable dropped mid-digit; scan position keeps running.
    repeat (1) step();
    en = 1'b0;
    repeat (3) begin
      step();
      check("en_off_an", 32'(an), 32'h0);
      check("en_off_seg", 32'(seg), 32'h0);
      check("en_off_dp", 32'(dp), 32'h0);
    end
    en = 1'b1;
    repeat (2 * FRAME) step();

    // Random inputs (including out-of-range) and enable.
    repeat (600) begin
      if ($urandom_range(0, 9) == 0) mins = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) secs = 6'($urandom_range(0, 63));
      en = ($urandom_range(0, 7) != 0);
      step();
    end

    // Reset asserted mid-scan acts immediately.
    en = 1'b1;
    mins = 6'd37; secs = 6'd18;
    repeat (FRAME + 6) step();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_an", 32'(an), 32'h0);
    check("midrst_seg", 32'(seg), 32'h0);
    check("midrst_dp", 32'(dp), 32'h0);
    release_reset();
    step();
    check("postrst_an", 32'(an), 32'h1);
    check("postrst_seg", 32'(seg), 32'h3F);
    repeat (2 * FRAME) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_display.md
# watch_display

Four-digit multiplexed 7-segment driver for the mins:secs watch counter. It consumes the counter's 6-bit `mins` and `secs` outputs and converts each to two BCD digits. It then scans the four digits onto a common segment bus with one-hot digit enables, blinking the colon once per second. It sits directly downstream of the watch counter and drives the board display pins.

## Interface
- `REFRESH_DIV`, default 1000: clocks each digit stays enabled. Legal range ≥ 2.
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  display enable. When low, all digit enables and segments are off; scanning continues.
- `mins`  in  6  minutes from the watch counter, valid range 0–59
- `secs`  in  6  seconds from the watch counter, valid range 0–59
- `seg`  out  7  segment drive, active-high, bit0=a … bit6=g
- `an`  out  4  digit enable, one-hot, active-high
  - bit0 = secs units
  - bit1 = secs tens
  - bit2 = mins units
  - bit3 = mins tens
- `dp`  out  1  colon/decimal point, active-high, asserted only alongside digit 2

## Operation
- **Prescaler `cnt`.** Width clog2(REFRESH_DIV). Counts 0 … REFRESH_DIV-1, then wraps to 0. Terminal count = `cnt == REFRESH_DIV-1`.
- **Digit index `idx` (2 bits).** Scan FSM with states D0→D1→D2→D3→D0. Advances only on terminal count.
- **Snapshot registers `snap_m`, `snap_s` (6 bits each).**
  - Loaded from `mins`/`secs` on the terminal-count cycle while `idx == 3`, i.e. on the same edge `idx` returns to 0.
  - Input changes at any other time are invisible until the next frame boundary, so no torn frames.
- **BCD split.** Combinational, from the snapshot.
  - For value v in 0–59: tens = v/10, units = v%10.
  - For v in 60–63, both digits of that field display dash (7'h40). The other field is unaffected.
- **Segment encoding.**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40 (hex, bit6..bit0 = g..a).
  - Leading zeros are displayed; no suppression.
- **Registered outputs, updated every clock:**
  - `an` <= en ? onehot(idx) : 0
  - `seg` <= en ? encode(digit(idx)) : 0
  - `dp` <= en && idx==2 && !snap_s[0]. The colon is lit on even seconds and dark on odd seconds.

## Timing
- **Reset (async assert).** cnt=0, idx=0, snap_m=0, snap_s=0, an=0000, seg=0000000, dp=0.
- **Output latency.** 1 clock after `idx`/snapshot/`en` changes, `an`/`seg`/`dp` reflect the change.
- **First edge after reset release with en=1.** an=0001, seg=3F (digit "0" of 00:00).
- **Digit dwell.** Each digit is enabled for exactly REFRESH_DIV clocks.
- **Frame length.** 4·REFRESH_DIV clocks.
- **First real snapshot.** Taken at the end of the first frame, 4·REFRESH_DIV clocks after reset release. Until then the display shows 00:00 with the colon lit.
- **`en` toggle.** Takes effect on outputs next edge. It never resets `cnt`, `idx` or the snapshot.
- **Reset mid-frame.** Immediate return to reset values. A partially scanned frame is discarded.
- **Simultaneous input change at the snapshot edge.** The value sampled at that edge is used, as with any other flop.

## Test plan
- **Reset values.** Assert rst mid-scan with REFRESH_DIV=4 → an=0000, seg=00, dp=0 immediately. After release with en=1, next edge → an=0001, seg=3F.
- **Scan and snapshot.** REFRESH_DIV=4, mins=23, secs=45 held. In frame 2 the sequence is:
  - an=0001 seg=6D (5)
  - an=0010 seg=66 (4)
  - an=0100 seg=4F (3) dp=0 (45 odd)
  - an=1000 seg=5B (2)
  
  Each step lasts 4 clocks.
- **Frame-coherent capture.** Change secs 45→46 while idx=1 → the current frame still shows 45. The next frame shows units 6 (7D) and dp=1 with digit 2.
- **Wrap values.** mins=59, secs=59 → digits 9,5,9,5 (6F,6D,6F,6D). Then mins=0, secs=0 → 3F on all four digits, dp=1.
- **Out-of-range.** mins=61, secs=07 → digits 2 and 3 = 40, digit 0 = 07, digit 1 = 3F.
- **Enable.** Drop en for 3 clocks mid-digit → an=0000, seg=00, dp=0 one edge later. On re-enable, scanning resumes at the uninterrupted `cnt`/`idx` position.
